rob_multi_issue: RTL and testbench

//  Parametrised circular reorder buffer for the out-of-order core. Sits between rename/dispatch and the free list.

---
 rtl/rob_pkg.sv | 30 +++
 rtl/rob_retire_sel.sv | 31 +++
 rtl/rob_multi_issue.sv | 207 ++++++++++++++++++++
 tb/tb_rob_multi_issue.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_pkg: entry layout, widths and helpers shared by the reorder buffer files.
// Revision: 1.0
// ----------------------------------------------------------------------------
package rob_pkg;

    localparam int OPCODE_W      = 7;
    localparam int ROB_NUM_PREGS = 64;
    localparam int ROB_PREG_W    = $clog2(ROB_NUM_PREGS);
    localparam int ROB_VAL_W     = 6;

    typedef struct packed {
        logic                  in_use;
        logic                  complete;
        logic [ROB_PREG_W-1:0] old_preg;
        logic [ROB_PREG_W-1:0] new_preg;
        logic [OPCODE_W-1:0]   opcode;
        logic [ROB_VAL_W-1:0]  value;
    } rob_entry_t;

    function automatic logic [ROB_NUM_PREGS-1:0] onehot_preg(input logic [ROB_PREG_W-1:0] preg);
        logic [ROB_NUM_PREGS-1:0] v_mask;
        v_mask       = '0;
        v_mask[preg] = 1'b1;
        return v_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_retire_sel: longest in_use&complete prefix of the RET_W oldest entries.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rob_retire_sel #(
    parameter int RET_W  = 2,
    parameter int NRET_W = $clog2(RET_W + 1)
) (
    input  logic [RET_W-1:0]  in_use_i,
    input  logic [RET_W-1:0]  complete_i,
    output logic [RET_W-1:0]  lane_valid_o,
    output logic [NRET_W-1:0] num_o
);

    always_comb begin
        logic v_run;
        v_run        = 1'b1;
        lane_valid_o = '0;
        num_o        = '0;
        for (int k = 0; k < RET_W; k++) begin
            v_run           = v_run & in_use_i[k] & complete_i[k];
            lane_valid_o[k] = v_run;
            if (v_run) begin
                num_o = num_o + NRET_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_multi_issue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_multi_issue: circular multi-dispatch / multi-retire reorder buffer.
// Optional feature macro ROB_FLUSH_EN adds flush_i (rename rollback flush).
// Revision: 1.0
// ----------------------------------------------------------------------------
module rob_multi_issue
    import rob_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int DISP_W    = 2,
    parameter int CMP_W     = 3,
    parameter int RET_W     = 2,
    parameter int NUM_PREGS = ROB_NUM_PREGS,
    parameter int VAL_W     = ROB_VAL_W,
    parameter int PREG_W    = $clog2(NUM_PREGS),
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CNT_W     = IDX_W + 1,
    parameter int NRET_W    = $clog2(RET_W + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef ROB_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic [DISP_W-1:0]          disp_valid_i,
    input  logic [DISP_W*PREG_W-1:0]   disp_old_preg_i,
    input  logic [DISP_W*PREG_W-1:0]   disp_new_preg_i,
    output logic                       disp_ready_o,
    output logic [DISP_W*IDX_W-1:0]    disp_idx_o,
    input  logic [CMP_W-1:0]           cmp_valid_i,
    input  logic [CMP_W*IDX_W-1:0]     cmp_idx_i,
    input  logic [CMP_W*OPCODE_W-1:0]  cmp_opcode_i,
    input  logic [CMP_W*VAL_W-1:0]     cmp_value_i,
    output logic [RET_W-1:0]           ret_valid_o,
    output logic [RET_W*OPCODE_W-1:0]  ret_opcode_o,
    output logic [RET_W*VAL_W-1:0]     ret_value_o,
    output logic [NUM_PREGS-1:0]       free_mask_o,
    output logic [NRET_W-1:0]          num_retired_o,
    output logic [CNT_W-1:0]           count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    rob_entry_t                 rob_q [DEPTH];
    rob_entry_t                 rob_d [DEPTH];
    logic [IDX_W-1:0]           head_q;
    logic [IDX_W-1:0]           tail_q;
    logic [CNT_W-1:0]           count_q;

    logic [RET_W-1:0]           ret_valid_q,  ret_valid_d;
    logic [RET_W*OPCODE_W-1:0]  ret_opcode_q, ret_opcode_d;
    logic [RET_W*VAL_W-1:0]     ret_value_q,  ret_value_d;
    logic [NUM_PREGS-1:0]       free_mask_q,  free_mask_d;
    logic [NRET_W-1:0]          num_ret_q,    num_ret_d;

    logic [RET_W-1:0]           w_head_in_use;
    logic [RET_W-1:0]           w_head_complete;
    logic [RET_W-1:0]           w_ret_lane;
    logic [NRET_W-1:0]          w_n_ret;
    logic [CNT_W-1:0]           w_n_disp;
    logic                       w_flush;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Ready is taken from the registered count, so same-cycle retire never frees a slot for dispatch.
    assign disp_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISP_W);
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));

    generate
        for (genvar k = 0; k < DISP_W; k++) begin : g_disp_idx
            assign disp_idx_o[k*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
        end
        for (genvar k = 0; k < RET_W; k++) begin : g_ret_gather
            assign w_head_in_use[k]   = rob_q[head_q + IDX_W'(k)].in_use;
            assign w_head_complete[k] = rob_q[head_q + IDX_W'(k)].complete;
        end
    endgenerate

    rob_retire_sel #(
        .RET_W  (RET_W),
        .NRET_W (NRET_W)
    ) u_retire_sel (
        .in_use_i     (w_head_in_use),
        .complete_i   (w_head_complete),
        .lane_valid_o (w_ret_lane),
        .num_o        (w_n_ret)
    );

    always_comb begin
        logic [IDX_W-1:0] v_idx;
        v_idx        = '0;
        rob_d        = rob_q;
        w_n_disp     = '0;
        ret_valid_d  = '0;
        ret_opcode_d = '0;
        ret_value_d  = '0;
        free_mask_d  = '0;
        num_ret_d    = w_n_ret;

        // Walk ports high to low so the lowest port's write lands last and wins.
        for (int p = CMP_W - 1; p >= 0; p--) begin
            v_idx = cmp_idx_i[p*IDX_W +: IDX_W];
            if (cmp_valid_i[p] && rob_q[v_idx].in_use) begin
                rob_d[v_idx].complete = 1'b1;
                rob_d[v_idx].opcode   = cmp_opcode_i[p*OPCODE_W +: OPCODE_W];
                rob_d[v_idx].value    = cmp_value_i[p*VAL_W +: VAL_W];
            end
        end

        for (int k = 0; k < RET_W; k++) begin
            v_idx = head_q + IDX_W'(k);
            if (w_ret_lane[k]) begin
                rob_d[v_idx].in_use   = 1'b0;
                rob_d[v_idx].complete = 1'b0;
                free_mask_d           = free_mask_d | onehot_preg(rob_q[v_idx].old_preg);
                ret_valid_d[k]        = 1'b1;
                ret_opcode_d[k*OPCODE_W +: OPCODE_W] = rob_q[v_idx].opcode;
                ret_value_d[k*VAL_W +: VAL_W]        = rob_q[v_idx].value;
            end
        end

        if (disp_ready_o) begin
            for (int k = 0; k < DISP_W; k++) begin
                v_idx = tail_q + IDX_W'(k);
                if (disp_valid_i[k]) begin
                    rob_d[v_idx] = '{in_use:   1'b1,
                                     complete: 1'b0,
                                     old_preg: disp_old_preg_i[k*PREG_W +: PREG_W],
                                     new_preg: disp_new_preg_i[k*PREG_W +: PREG_W],
                                     opcode:   '0,
                                     value:    '0};
                    w_n_disp = w_n_disp + CNT_W'(1);
                end
            end
        end

        // Flush rolls back renames: every live entry returns its new mapping.
        if (w_flush) begin
            free_mask_d  = '0;
            ret_valid_d  = '0;
            ret_opcode_d = '0;
            ret_value_d  = '0;
            num_ret_d    = '0;
            w_n_disp     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rob_q[i].in_use) begin
                    free_mask_d = free_mask_d | onehot_preg(rob_q[i].new_preg);
                end
                rob_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ret_valid_q  <= '0;
            ret_opcode_q <= '0;
            ret_value_q  <= '0;
            free_mask_q  <= '0;
            num_ret_q    <= '0;
        end else begin
            rob_q        <= rob_d;
            ret_valid_q  <= ret_valid_d;
            ret_opcode_q <= ret_opcode_d;
            ret_value_q  <= ret_value_d;
            free_mask_q  <= free_mask_d;
            num_ret_q    <= num_ret_d;
            if (w_flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + IDX_W'(w_n_ret);
                tail_q  <= tail_q + IDX_W'(w_n_disp);
                count_q <= count_q + w_n_disp - CNT_W'(w_n_ret);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((disp_valid_i & (disp_valid_i + DISP_W'(1))) == '0)
                else $error("disp_valid_i lanes are not contiguous from lane 0");
        end
    end

    assign ret_valid_o   = ret_valid_q;
    assign ret_opcode_o  = ret_opcode_q;
    assign ret_value_o   = ret_value_q;
    assign free_mask_o   = free_mask_q;
    assign num_retired_o = num_ret_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_issue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rob_multi_issue: queue-based ROB reference model with retire scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rob_multi_issue;

    localparam int DEPTH     = 32;
    localparam int DISP_W    = 2;
    localparam int CMP_W     = 3;
    localparam int RET_W     = 2;
    localparam int NUM_PREGS = 64;
    localparam int PREG_W    = 6;
    localparam int VAL_W     = 6;
    localparam int IDX_W     = 5;
    localparam int CNT_W     = 6;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
`ifdef ROB_FLUSH_EN
    logic                  flush_i = 1'b0;
`endif
    logic [DISP_W-1:0]         disp_valid_i = '0;
    logic [DISP_W*PREG_W-1:0]  disp_old_preg_i = '0;
    logic [DISP_W*PREG_W-1:0]  disp_new_preg_i = '0;
    logic                      disp_ready_o;
    logic [DISP_W*IDX_W-1:0]   disp_idx_o;
    logic [CMP_W-1:0]          cmp_valid_i = '0;
    logic [CMP_W*IDX_W-1:0]    cmp_idx_i = '0;
    logic [CMP_W*7-1:0]        cmp_opcode_i = '0;
    logic [CMP_W*VAL_W-1:0]    cmp_value_i = '0;
    logic [RET_W-1:0]          ret_valid_o;
    logic [RET_W*7-1:0]        ret_opcode_o;
    logic [RET_W*VAL_W-1:0]    ret_value_o;
    logic [NUM_PREGS-1:0]      free_mask_o;
    logic [1:0]                num_retired_o;
    logic [CNT_W-1:0]          count_o;
    logic                      empty_o;
    logic                      full_o;

    always #5 clk = ~clk;

    rob_multi_issue dut (
        .clk             (clk),
        .reset           (reset),
`ifdef ROB_FLUSH_EN
        .flush_i         (flush_i),
`endif
        .disp_valid_i    (disp_valid_i),
        .disp_old_preg_i (disp_old_preg_i),
        .disp_new_preg_i (disp_new_preg_i),
        .disp_ready_o    (disp_ready_o),
        .disp_idx_o      (disp_idx_o),
        .cmp_valid_i     (cmp_valid_i),
        .cmp_idx_i       (cmp_idx_i),
        .cmp_opcode_i    (cmp_opcode_i),
        .cmp_value_i     (cmp_value_i),
        .ret_valid_o     (ret_valid_o),
        .ret_opcode_o    (ret_opcode_o),
        .ret_value_o     (ret_value_o),
        .free_mask_o     (free_mask_o),
        .num_retired_o   (num_retired_o),
        .count_o         (count_o),
        .empty_o         (empty_o),
        .full_o          (full_o)
    );

    // Program-order model: front of the queue is the oldest (head) entry.
    typedef struct {
        int idx;
        int old_p;
        int new_p;
        bit done;
        int op;
        int val;
    } ent_t;

    typedef struct {
        int          cyc;
        int          n;
        int          op  [2];
        int          val [2];
        logic [63:0] mask;
    } exp_t;

    ent_t mq  [$];
    exp_t sbq [$];
    int   m_tail  = 0;
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    logic [1:0] s_dv;
    int         s_old [2];
    int         s_new [2];
    logic [2:0] s_cv;
    int         s_idx [3];
    int         s_op  [3];
    int         s_val [3];
    bit         s_reset;
    bit         s_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        s_dv = '0; s_cv = '0; s_reset = 0; s_flush = 0;
        for (int k = 0; k < 2; k++) begin s_old[k] = 0; s_new[k] = 0; end
        for (int p = 0; p < 3; p++) begin s_idx[p] = 0; s_op[p] = 0; s_val[p] = 0; end
    endtask

    // One clock: check status against the model, drive stimulus, advance the model.
    task automatic cycle();
        exp_t e;
        logic [63:0] mask;
        bit ready, dup;
        @(negedge clk);
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("empty", 64'(empty_o), 64'(mq.size() == 0));
        chk("full",  64'(full_o),  64'(mq.size() == DEPTH));
        chk("ready", 64'(disp_ready_o), 64'((DEPTH - mq.size()) >= DISP_W));
        chk("disp_idx0", 64'(disp_idx_o[4:0]), 64'(m_tail % DEPTH));
        chk("disp_idx1", 64'(disp_idx_o[9:5]), 64'((m_tail + 1) % DEPTH));

        reset           = s_reset;
        disp_valid_i    = s_dv;
        disp_old_preg_i = {6'(s_old[1]), 6'(s_old[0])};
        disp_new_preg_i = {6'(s_new[1]), 6'(s_new[0])};
        cmp_valid_i     = s_cv;
        cmp_idx_i       = {5'(s_idx[2]), 5'(s_idx[1]), 5'(s_idx[0])};
        cmp_opcode_i    = {7'(s_op[2]), 7'(s_op[1]), 7'(s_op[0])};
        cmp_value_i     = {6'(s_val[2]), 6'(s_val[1]), 6'(s_val[0])};
`ifdef ROB_FLUSH_EN
        flush_i         = s_flush;
`endif

        if (s_reset) begin
            mq.delete();
            m_tail = 0;
            return;
        end
`ifdef ROB_FLUSH_EN
        if (s_flush) begin
            mask = '0;
            foreach (mq[j]) mask |= 64'(1) << mq[j].new_p;
            if (mask != 0) begin
                e.cyc = cyc_cnt + 1; e.n = 0; e.op = '{0, 0}; e.val = '{0, 0}; e.mask = mask;
                sbq.push_back(e);
            end
            mq.delete();
            m_tail = 0;
            return;
        end
`endif
        ready = (DEPTH - mq.size()) >= DISP_W;

        e.cyc = cyc_cnt + 1; e.n = 0; e.op = '{0, 0}; e.val = '{0, 0}; e.mask = '0;
        while (e.n < RET_W && mq.size() > 0 && mq[0].done) begin
            e.op[e.n]  = mq[0].op;
            e.val[e.n] = mq[0].val;
            e.mask    |= 64'(1) << mq[0].old_p;
            void'(mq.pop_front());
            e.n++;
        end
        if (e.n > 0) sbq.push_back(e);

        for (int p = 0; p < CMP_W; p++) begin
            dup = 0;
            for (int q = 0; q < p; q++)
                if (s_cv[q] && s_idx[q] == s_idx[p]) dup = 1;
            if (s_cv[p] && !dup) begin
                foreach (mq[j]) begin
                    if (mq[j].idx == s_idx[p]) begin
                        mq[j].done = 1; mq[j].op = s_op[p]; mq[j].val = s_val[p];
                    end
                end
            end
        end

        if (ready) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (s_dv[k]) begin
                    mq.push_back('{idx: m_tail, old_p: s_old[k], new_p: s_new[k], done: 0, op: 0, val: 0});
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    endtask

    // Complete every outstanding entry, then let the ROB drain.
    task automatic drain();
        int n;
        for (int guard = 0; guard < 40; guard++) begin
            idle();
            n = 0;
            foreach (mq[j]) begin
                if (!mq[j].done && n < CMP_W) begin
                    s_cv[n] = 1'b1; s_idx[n] = mq[j].idx;
                    s_op[n] = int'($urandom_range(0, 127)); s_val[n] = int'($urandom_range(0, 63));
                    n++;
                end
            end
            cycle();
        end
        chk("drain_empty", 64'(mq.size()), 64'(0));
    endtask

    task automatic dispatch(input logic [1:0] dv);
        idle();
        s_dv = dv;
        for (int k = 0; k < 2; k++) begin
            s_old[k] = int'($urandom_range(0, 63));
            s_new[k] = int'($urandom_range(0, 63));
        end
        cycle();
    endtask

    // Monitor: compares each retire/free pulse with the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            while (sbq.size() > 0 && sbq[0].cyc < cyc_cnt) begin
                e = sbq.pop_front();
                checks++; errors++;
                $display("FAIL missed_retire: expected n=%0d mask=0x%0h at cycle %0d, nothing seen", e.n, e.mask, e.cyc);
            end
            if (num_retired_o != 0 || ret_valid_o != 0 || free_mask_o != 0) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_retire: got n=%0d mask=0x%0h, expected no output", num_retired_o, free_mask_o);
                end else begin
                    e = sbq.pop_front();
                    chk("ret_cycle", 64'(cyc_cnt), 64'(e.cyc));
                    chk("num_retired", 64'(num_retired_o), 64'(e.n));
                    chk("ret_valid", 64'(ret_valid_o), 64'((1 << e.n) - 1));
                    chk("free_mask", free_mask_o, e.mask);
                    for (int k = 0; k < e.n; k++) begin
                        chk("ret_opcode", 64'(ret_opcode_o[k*7 +: 7]), 64'(e.op[k]));
                        chk("ret_value", 64'(ret_value_o[k*VAL_W +: VAL_W]), 64'(e.val[k]));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, rate;
        // Reset state and first dispatch group.
        idle(); s_reset = 1; cycle();
        idle(); cycle();
        chk("rst_num_retired", 64'(num_retired_o), 64'(0));
        chk("rst_free_mask", free_mask_o, 64'(0));
        chk("t1_idx0", 64'(disp_idx_o[4:0]), 64'(0));
        chk("t1_idx1", 64'(disp_idx_o[9:5]), 64'(1));
        idle(); s_dv = 2'b11; s_old = '{3, 5}; s_new = '{40, 41}; cycle();
        idle(); cycle();
        chk("t1_count", 64'(count_o), 64'(2));
        chk("t1_no_retire", 64'(num_retired_o), 64'(0));

        // Out-of-order completion; both retire together afterwards.
        idle(); s_cv = 3'b001; s_idx[0] = 1; s_op[0] = 7'h11; s_val[0] = 7; cycle();
        idle(); s_cv = 3'b001; s_idx[0] = 0; s_op[0] = 7'h22; s_val[0] = 9; cycle();
        chk("t2_wait", 64'(num_retired_o), 64'(0));
        idle(); cycle();
        idle(); cycle();
        chk("t2_num", 64'(num_retired_o), 64'(2));
        chk("t2_mask", free_mask_o, 64'h28);
        chk("t2_val0", 64'(ret_value_o[5:0]), 64'(9));
        chk("t2_val1", 64'(ret_value_o[11:6]), 64'(7));

        // Fill to full; extra dispatch ignored.
        idle(); s_reset = 1; cycle();
        for (int i = 0; i < 16; i++) dispatch(2'b11);
        dispatch(2'b11);
        chk("t3_full", 64'(full_o), 64'(1));
        chk("t3_ready", 64'(disp_ready_o), 64'(0));
        dispatch(2'b01);
        chk("t3_count", 64'(count_o), 64'(32));
        drain();

        // Pointer wrap: head and tail at 31.
        idle(); s_reset = 1; cycle();
        for (int i = 0; i < 15; i++) dispatch(2'b11);
        dispatch(2'b01);
        drain();
        chk("t4_idx0", 64'(disp_idx_o[4:0]), 64'(31));
        chk("t4_idx1", 64'(disp_idx_o[9:5]), 64'(0));
        dispatch(2'b11);
        idle(); s_cv = 3'b011; s_idx[0] = 31; s_val[0] = 21; s_op[0] = 5; s_idx[1] = 0; s_val[1] = 42; s_op[1] = 6; cycle();
        idle(); cycle();
        idle(); cycle();
        chk("t4_num", 64'(num_retired_o), 64'(2));
        chk("t4_val0", 64'(ret_value_o[5:0]), 64'(21));
        chk("t4_val1", 64'(ret_value_o[11:6]), 64'(42));
        chk("t4_head_wrap", 64'(disp_idx_o[4:0]), 64'(1));

        // Same index on ports 0 and 2; then completion to a free entry.
        dispatch(2'b01);
        idle(); s_cv = 3'b101; s_idx[0] = 1; s_val[0] = 1; s_op[0] = 3; s_idx[2] = 1; s_val[2] = 2; s_op[2] = 4; cycle();
        idle(); cycle();
        idle(); cycle();
        chk("t5_num", 64'(num_retired_o), 64'(1));
        chk("t5_val", 64'(ret_value_o[5:0]), 64'(1));
        idle(); s_cv = 3'b001; s_idx[0] = 10; s_val[0] = 5; cycle();
        idle(); cycle();
        idle(); cycle();
        chk("t5_free_cmp_count", 64'(count_o), 64'(0));
        chk("t5_free_cmp_ret", 64'(num_retired_o), 64'(0));

`ifdef ROB_FLUSH_EN
        idle(); s_reset = 1; cycle();
        idle(); s_dv = 2'b11; s_old = '{1, 2}; s_new = '{40, 41}; cycle();
        idle(); s_dv = 2'b11; s_old = '{3, 4}; s_new = '{42, 43}; cycle();
        idle(); s_flush = 1; cycle();
        idle(); cycle();
        chk("t6_mask", free_mask_o, 64'hF << 40);
        chk("t6_empty", 64'(empty_o), 64'(1));
        chk("t6_ret_valid", 64'(ret_valid_o), 64'(0));
`endif

        // Randomized traffic with varying completion pressure.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rate    = ((c / 300) % 2 == 1) ? 15 : 70;
            s_reset = ($urandom_range(0, 599) == 0);
`ifdef ROB_FLUSH_EN
            s_flush = ($urandom_range(0, 249) == 0);
`endif
            r = int'($urandom_range(0, 3));
            s_dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            for (int k = 0; k < 2; k++) begin
                s_old[k] = int'($urandom_range(0, 63));
                s_new[k] = int'($urandom_range(0, 63));
            end
            for (int p = 0; p < CMP_W; p++) begin
                s_cv[p] = ($urandom_range(0, 99) < rate);
                if (mq.size() > 0 && $urandom_range(0, 7) != 0)
                    s_idx[p] = mq[$urandom_range(0, mq.size() - 1)].idx;
                else
                    s_idx[p] = int'($urandom_range(0, DEPTH - 1));
                s_op[p]  = int'($urandom_range(0, 127));
                s_val[p] = int'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 7) == 0) s_idx[2] = s_idx[0];
            cycle();
        end

        drain();
        idle(); cycle();
        idle(); cycle();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
